// File: rtl/sc_game_progress_tracker.sv
// ---------------------------------------------------------------------------
// sc_game_progress_tracker
//
// Game-progress datapath that sits in front of the game state machine.
// It keeps the lives counter, the level counter, the filled-house mask and a
// hold timer. It takes the FSM's active-low event strobes and returns the
// active-low comparator flags the FSM branches on. It also drives the
// lives, level and house buses to the display path.
//
// After each accepted gameplay event (lose life, next level, house), a
// two-state transition machine (IDLE/HOLD) ignores further gameplay events
// for TRANS_CYCLES clocks. Because of this, a strobe held low produces one
// event per hold window. Restart (start) is accepted in any state and
// aborts a running hold.
//
// Ports
//   SC_STATEMACHINEGAME_CLOCK_50      in   system clock
//   SC_STATEMACHINEGAME_RESET_InHigh  in   async reset, active-high
//   start_InLow                       in   0 = restart game
//   loseLife_InLow                    in   0 = frog died
//   nextLevel_InLow                   in   0 = level completed
//   house_InLow                       in   0 = frog reached a house
//   houseIndex_InBUS                  in   house hit, valid with house_InLow
//   LifesCounterComparator_OutLow     out  0 when lives == 0
//   LevelCounterComparator_OutLow     out  0 when level == LEVEL_MAX
//   AllHouses_OutLow                  out  0 when every house is filled
//   TransitionBusy_OutHigh            out  1 while the hold timer runs
//   Lives_OutBUS                      out  current lives
//   Level_OutBUS                      out  current level
//   HouseMask_OutBUS                  out  bit i = house i filled
// ---------------------------------------------------------------------------
module sc_game_progress_tracker #(
  parameter int LIFE_W       = 3,
  parameter int LIVES_INIT   = 3,
  parameter int LEVEL_W      = 3,
  parameter int LEVEL_MAX    = 4,
  parameter int HOUSES       = 4,
  parameter int TRANS_CYCLES = 25000000,
  parameter int TRANS_W      = 25,
  localparam int HIDX_W      = (HOUSES > 1) ? $clog2(HOUSES) : 1
) (
  input  logic                SC_STATEMACHINEGAME_CLOCK_50,
  input  logic                SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic                start_InLow,
  input  logic                loseLife_InLow,
  input  logic                nextLevel_InLow,
  input  logic                house_InLow,
  input  logic [HIDX_W-1:0]   houseIndex_InBUS,
  output logic                LifesCounterComparator_OutLow,
  output logic                LevelCounterComparator_OutLow,
  output logic                AllHouses_OutLow,
  output logic                TransitionBusy_OutHigh,
  output logic [LIFE_W-1:0]   Lives_OutBUS,
  output logic [LEVEL_W-1:0]  Level_OutBUS,
  output logic [HOUSES-1:0]   HouseMask_OutBUS
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [LIFE_W-1:0]  LIVES_RST = LIFE_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(LEVEL_MAX);
  localparam logic [TRANS_W-1:0] HOLD_LOAD = TRANS_W'(TRANS_CYCLES - 1);

  state_e              state_q, state_d;
  logic [TRANS_W-1:0]  timer_q, timer_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [HOUSES-1:0]   mask_q,  mask_d;

  logic                house_idx_ok;
  logic                start_hold;

  // If HOUSES is not a power of two, an index can be out of range. Such an
  // event is dropped entirely and does not start a hold.
  assign house_idx_ok = (32'(houseIndex_InBUS) < 32'(HOUSES));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lives_d    = lives_q;
    level_d    = level_q;
    mask_d     = mask_q;
    start_hold = 1'b0;

    if (!start_InLow) begin
      // Restart has top priority in both states and cancels any hold.
      state_d = ST_IDLE;
      timer_d = '0;
      lives_d = LIVES_RST;
      level_d = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Fixed priority: only the highest-priority strobe is used.
          if (!loseLife_InLow) begin
            if (lives_q != '0) lives_d = lives_q - LIFE_W'(1);
            start_hold = 1'b1;
          end else if (!nextLevel_InLow) begin
            if (level_q != LEVEL_TOP) level_d = level_q + LEVEL_W'(1);
            mask_d     = '0;
            start_hold = 1'b1;
          end else if (!house_InLow && house_idx_ok) begin
            // A house that is already filled still opens a hold window.
            mask_d     = mask_q | (HOUSES'(1) << houseIndex_InBUS);
            start_hold = 1'b1;
          end
          if (start_hold) begin
            state_d = ST_HOLD;
            timer_d = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          // Gameplay strobes are ignored here. The window is TRANS_CYCLES
          // clocks long: loaded with N-1, it leaves on the edge that sees 0.
          if (timer_q == '0) state_d = ST_IDLE;
          else               timer_d = timer_q - TRANS_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops then
  // update together from the values they held before the edge.
  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or
              posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lives_q <= LIVES_RST;
      level_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lives_q <= lives_d;
      level_q <= level_d;
      mask_q  <= mask_d;
    end
  end

  assign LifesCounterComparator_OutLow = (lives_q != '0);
  assign LevelCounterComparator_OutLow = (level_q != LEVEL_TOP);
  assign AllHouses_OutLow              = ~(&mask_q);
  assign TransitionBusy_OutHigh        = (state_q == ST_HOLD);
  assign Lives_OutBUS                  = lives_q;
  assign Level_OutBUS                  = level_q;
  assign HouseMask_OutBUS              = mask_q;

endmodule

// File: tb/tb_sc_game_progress_tracker.sv
// ---------------------------------------------------------------------------
// tb_sc_game_progress_tracker
//
// Directed bench for sc_game_progress_tracker with TRANS_CYCLES = 4. Each
// task drives one scenario and compares outputs 1 ns after the rising edge
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sc_game_progress_tracker;

  logic       clk;
  logic       rst;
  logic       start_n, lose_n, next_n, house_n;
  logic [1:0] hidx;
  logic       lives_flag_n, level_flag_n, all_houses_n, busy;
  logic [2:0] lives, level;
  logic [3:0] mask;

  int passed = 0;
  int total  = 0;

  sc_game_progress_tracker #(
    .LIFE_W(3), .LIVES_INIT(3), .LEVEL_W(3), .LEVEL_MAX(4),
    .HOUSES(4), .TRANS_CYCLES(4), .TRANS_W(3)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50     (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh (rst),
    .start_InLow                      (start_n),
    .loseLife_InLow                   (lose_n),
    .nextLevel_InLow                  (next_n),
    .house_InLow                      (house_n),
    .houseIndex_InBUS                 (hidx),
    .LifesCounterComparator_OutLow    (lives_flag_n),
    .LevelCounterComparator_OutLow    (level_flag_n),
    .AllHouses_OutLow                 (all_houses_n),
    .TransitionBusy_OutHigh           (busy),
    .Lives_OutBUS                     (lives),
    .Level_OutBUS                     (level),
    .HouseMask_OutBUS                 (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    // Clean state right after power-up reset.
    do_reset();
    total++; if (lives !== 3'd3) $display("FAIL reset_lives: got %0d expected 3", lives); else passed++;
    total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
    total++; if ({lives_flag_n, level_flag_n, all_houses_n, busy} !== 4'b1110)
      $display("FAIL reset_flags: got %b expected 1110", {lives_flag_n, level_flag_n, all_houses_n, busy});
    else passed++;
    // Enter HOLD, let the timer reach 2, then reset asynchronously.
    lose_n = 1'b0; step(); lose_n = 1'b1;
    step();
    total++; if (busy !== 1'b1 || lives !== 3'd2)
      $display("FAIL pre_reset_hold: got busy=%0d lives=%0d expected busy=1 lives=2", busy, lives);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({busy, lives, level, mask} !== {1'b0, 3'd3, 3'd0, 4'd0})
      $display("FAIL async_reset: got busy=%0d lives=%0d level=%0d mask=%b expected 0/3/0/0000",
               busy, lives, level, mask);
    else passed++;
    total++; if ({lives_flag_n, level_flag_n, all_houses_n} !== 3'b111)
      $display("FAIL async_reset_flags: got %b expected 111", {lives_flag_n, level_flag_n, all_houses_n});
    else passed++;
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_lose_life();
    int cnt;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      lose_n = 1'b0; step(); lose_n = 1'b1;
      total++; if (lives !== 3'(2 - i) || busy !== 1'b1)
        $display("FAIL lose_life_%0d: got lives=%0d busy=%0d expected lives=%0d busy=1", i, lives, busy, 2 - i);
      else passed++;
      step(5);
    end
    total++; if (lives_flag_n !== 1'b0) $display("FAIL lives_zero_flag: got %0d expected 0", lives_flag_n); else passed++;
    // Saturated: lives stays 0, but the hold still runs for 4 cycles.
    lose_n = 1'b0; step(); lose_n = 1'b1;
    total++; if (lives !== 3'd0) $display("FAIL lives_saturate: got %0d expected 0", lives); else passed++;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) cnt++;
      step();
    end
    total++; if (cnt != 4) $display("FAIL busy_len_at_zero: got %0d expected 4", cnt); else passed++;
  endtask

  task automatic test_held_strobe();
    logic [9:0] seen;
    do_reset();
    lose_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen[k] = busy;
    end
    lose_n = 1'b1;
    total++; if (lives !== 3'd1) $display("FAIL held_lives: got %0d expected 1", lives); else passed++;
    total++; if (seen !== 10'b0111101111) $display("FAIL held_busy_pattern: got %b expected 0111101111", seen); else passed++;
    step(2);
  endtask

  task automatic test_houses();
    logic [3:0] exp_mask;
    do_reset();
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      house_n = 1'b0; hidx = 2'(i); step(); house_n = 1'b1;
      exp_mask[i] = 1'b1;
      total++; if (mask !== exp_mask) $display("FAIL house_%0d_mask: got %b expected %b", i, mask, exp_mask); else passed++;
      step(5);
    end
    total++; if (all_houses_n !== 1'b0) $display("FAIL all_houses_flag: got %0d expected 0", all_houses_n); else passed++;
    // Re-hitting a filled house leaves the mask but still starts a hold.
    house_n = 1'b0; hidx = 2'd1; step(); house_n = 1'b1;
    total++; if (mask !== 4'b1111 || busy !== 1'b1)
      $display("FAIL house_repeat: got mask=%b busy=%0d expected 1111 busy=1", mask, busy);
    else passed++;
    step(5);
    next_n = 1'b0; step(); next_n = 1'b1;
    total++; if ({level, mask, all_houses_n} !== {3'd1, 4'b0000, 1'b1})
      $display("FAIL next_clears_mask: got level=%0d mask=%b all=%0d expected 1/0000/1", level, mask, all_houses_n);
    else passed++;
    step(5);
  endtask

  task automatic test_priority();
    do_reset();
    lose_n = 1'b0; next_n = 1'b0; house_n = 1'b0; hidx = 2'd2; step();
    lose_n = 1'b1; next_n = 1'b1; house_n = 1'b1;
    total++; if ({lives, level, mask} !== {3'd2, 3'd0, 4'b0000})
      $display("FAIL priority_lose_wins: got lives=%0d level=%0d mask=%b expected 2/0/0000", lives, level, mask);
    else passed++;
    // nextLevel during HOLD is ignored.
    next_n = 1'b0; step(); next_n = 1'b1;
    total++; if (level !== 3'd0) $display("FAIL hold_ignores_next: got %0d expected 0", level); else passed++;
    // start during HOLD aborts the hold.
    start_n = 1'b0; step(); start_n = 1'b1;
    total++; if ({busy, lives, level} !== {1'b0, 3'd3, 3'd0})
      $display("FAIL start_in_hold: got busy=%0d lives=%0d level=%0d expected 0/3/0", busy, lives, level);
    else passed++;
    // start beats a simultaneous loseLife.
    start_n = 1'b0; lose_n = 1'b0; step(); start_n = 1'b1; lose_n = 1'b1;
    total++; if ({busy, lives} !== {1'b0, 3'd3})
      $display("FAIL start_beats_lose: got busy=%0d lives=%0d expected 0/3", busy, lives);
    else passed++;
  endtask

  task automatic test_level();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      next_n = 1'b0; step(); next_n = 1'b1;
      total++; if (level !== 3'(i)) $display("FAIL level_%0d: got %0d expected %0d", i, level, i); else passed++;
      total++; if (level_flag_n !== (i != 4)) $display("FAIL level_flag_%0d: got %0d expected %0d", i, level_flag_n, (i != 4)); else passed++;
      step(5);
    end
    next_n = 1'b0; step(); next_n = 1'b1;
    total++; if (level !== 3'd4 || level_flag_n !== 1'b0 || busy !== 1'b1)
      $display("FAIL level_saturate: got level=%0d flag=%0d busy=%0d expected 4/0/1", level, level_flag_n, busy);
    else passed++;
    step(5);
  endtask

  initial begin
    rst = 1'b1; start_n = 1'b1; lose_n = 1'b1; next_n = 1'b1; house_n = 1'b1; hidx = 2'd0;
    #12;
    test_reset();
    test_lose_life();
    test_held_strobe();
    test_houses();
    test_priority();
    test_level();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
